// File: rtl/ins_dispatch_ctrl_pkg.sv
// Shared constants for the instruction dispatcher: opcodes, error codes, FSM states.
// INS_RAM_DATA_WIDTH may be supplied by the build; 32 is the fallback word width.
`ifndef INS_RAM_DATA_WIDTH
`define INS_RAM_DATA_WIDTH 32
`endif

package ins_dispatch_ctrl_pkg;

  localparam int INS_ADDR_W_DEF = 10;
  localparam int INS_DW_DEF     = `INS_RAM_DATA_WIDTH;
  localparam int OPC_W_DEF      = 8;
  localparam int N_UNITS_DEF    = 4;
  localparam int RD_LAT_DEF     = 2;

  localparam logic [7:0] OPC_END   = 8'd0;
  localparam logic [7:0] OPC_CONV  = 8'd1;
  localparam logic [7:0] OPC_UNIT1 = 8'd2;
  localparam logic [7:0] OPC_UNIT2 = 8'd3;
  localparam logic [7:0] OPC_UNIT3 = 8'd4;

  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_ILLEGAL_OPC   = 2'd1,
    ERR_SPURIOUS_DONE = 2'd2
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_DISPATCH,
    ST_EXEC,
    ST_FIN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ins_dispatch_ctrl_if.sv
// Bundle of program control, instruction RAM and execution unit signals.
// master is the dispatcher side, slave is the environment (host, RAM, units).
interface ins_dispatch_ctrl_if
  import ins_dispatch_ctrl_pkg::*;
#(
  parameter int INS_ADDR_W = INS_ADDR_W_DEF,
  parameter int INS_DW     = INS_DW_DEF,
  parameter int N_UNITS    = N_UNITS_DEF
) ();

  logic                  start_pulse;
  logic [INS_ADDR_W-1:0] ins_base_addr;
  logic [15:0]           ins_count;
  logic                  done_pulse;
  logic                  err_pulse;
  logic [1:0]            err_code;
  logic                  busy;
  logic [15:0]           n_exec;
  logic                  ins_ram_rd_en;
  logic [INS_ADDR_W-1:0] ins_ram_rd_addr;
  logic [INS_DW-1:0]     ins_ram_dout;
  logic [INS_DW-1:0]     unit_ins;
  logic [N_UNITS-1:0]    unit_start_pulse;
  logic [N_UNITS-1:0]    unit_done_pulse;

  modport master (
    input  start_pulse, ins_base_addr, ins_count, ins_ram_dout, unit_done_pulse,
    output done_pulse, err_pulse, err_code, busy, n_exec,
           ins_ram_rd_en, ins_ram_rd_addr, unit_ins, unit_start_pulse
  );

  modport slave (
    output start_pulse, ins_base_addr, ins_count, ins_ram_dout, unit_done_pulse,
    input  done_pulse, err_pulse, err_code, busy, n_exec,
           ins_ram_rd_en, ins_ram_rd_addr, unit_ins, unit_start_pulse
  );

endinterface

// File: rtl/ins_dispatch_ctrl_fetch_pipe.sv
// Instruction RAM read-latency tracker and capture register for the broadcast word.
// The captured word only changes on a completed read, so it stays stable through execution.
module ins_fetch_pipe
  import ins_dispatch_ctrl_pkg::*;
#(
  parameter int INS_DW = INS_DW_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch_i,
  input  logic              wait_i,
  input  logic [INS_DW-1:0] ram_dout_i,
  output logic              rd_valid_o,
  output logic [INS_DW-1:0] unit_ins_o,
  output logic [OPC_W-1:0]  opc_o
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [INS_DW-1:0] ins_q;
  logic [OPC_W-1:0]  opc_q;

  // Launch coincides with the strobe cycle; data lands RD_LAT cycles later.
  assign rd_valid_o = wait_i && (cnt_q == '0);
  assign unit_ins_o = ins_q;
  assign opc_o      = opc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ins_q <= '0;
      opc_q <= '0;
    end else begin
      if (launch_i) begin
        cnt_q <= CNT_W'(RD_LAT - 1);
      end else if (wait_i && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (rd_valid_o) begin
        ins_q <= ram_dout_i;
        opc_q <= ram_dout_i[OPC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ins_dispatch_ctrl.sv
// Instruction sequencer: fetches, decodes and dispatches one instruction at a time
// to a single execution unit, waiting for its done before fetching the next.
module ins_dispatch_ctrl
  import ins_dispatch_ctrl_pkg::*;
#(
  parameter int INS_ADDR_W = INS_ADDR_W_DEF,
  parameter int INS_DW     = INS_DW_DEF,
  parameter int OPC_W      = OPC_W_DEF,
  parameter int N_UNITS    = N_UNITS_DEF,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ins_dispatch_ctrl_if.master ctrl_io
);

  state_e                state_q;
  logic [INS_ADDR_W-1:0] pc_q;
  logic [15:0]           n_left_q;
  logic [15:0]           n_exec_q;
  err_code_e             err_code_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  rd_en_q;
  logic [INS_ADDR_W-1:0] rd_addr_q;
  logic [N_UNITS-1:0]    start_q;

  logic                  rd_valid;
  logic [INS_DW-1:0]     unit_ins;
  logic [OPC_W-1:0]      opc;
  logic [N_UNITS-1:0]    opc_hot;
  logic [N_UNITS-1:0]    unit_done;
  logic                  any_done;
  logic                  stray_done;
  logic                  sel_done;

  ins_fetch_pipe #(
    .INS_DW (INS_DW),
    .OPC_W  (OPC_W),
    .RD_LAT (RD_LAT)
  ) u_fetch_pipe (
    .clk        (clk),
    .rst        (rst),
    .launch_i   (state_q == ST_FETCH),
    .wait_i     (state_q == ST_WAIT_RD),
    .ram_dout_i (ctrl_io.ins_ram_dout),
    .rd_valid_o (rd_valid),
    .unit_ins_o (unit_ins),
    .opc_o      (opc)
  );

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_opc_dec
    assign opc_hot[gi] = (opc == OPC_W'(gi + 1));
  end

  assign unit_done  = ctrl_io.unit_done_pulse;
  assign any_done   = |unit_done;
  assign stray_done = |(unit_done & ~opc_hot);
  assign sel_done   = |(unit_done & opc_hot);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      n_left_q   <= '0;
      n_exec_q   <= '0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      start_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      start_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // busy is still high here only in the cycle right after done_pulse
          if (busy_q && any_done) begin
            err_code_q <= ERR_SPURIOUS_DONE;
            state_q    <= ST_ERR;
          end else begin
            busy_q <= 1'b0;
            if (ctrl_io.start_pulse) begin
              pc_q       <= ctrl_io.ins_base_addr;
              n_left_q   <= ctrl_io.ins_count;
              n_exec_q   <= '0;
              err_code_q <= ERR_NONE;
              busy_q     <= 1'b1;
              if (ctrl_io.ins_count == 16'd0) begin
                state_q <= ST_FIN;
              end else begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= ctrl_io.ins_base_addr;
                state_q   <= ST_FETCH;
              end
            end
          end
        end
        ST_FETCH, ST_WAIT_RD: begin
          if (any_done) begin
            err_code_q <= ERR_SPURIOUS_DONE;
            state_q    <= ST_ERR;
          end else if (state_q == ST_FETCH) begin
            state_q <= ST_WAIT_RD;
          end else if (rd_valid) begin
            state_q <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (any_done) begin
            err_code_q <= ERR_SPURIOUS_DONE;
            state_q    <= ST_ERR;
          end else if (opc == OPC_W'(OPC_END)) begin
            state_q <= ST_FIN;
          end else if (opc <= OPC_W'(N_UNITS)) begin
            start_q <= opc_hot;
            if (n_exec_q != 16'hFFFF) begin
              n_exec_q <= n_exec_q + 16'd1;
            end
            state_q <= ST_EXEC;
          end else begin
            err_code_q <= ERR_ILLEGAL_OPC;
            state_q    <= ST_ERR;
          end
        end
        ST_EXEC: begin
          if (stray_done) begin
            err_code_q <= ERR_SPURIOUS_DONE;
            state_q    <= ST_ERR;
          end else if (sel_done) begin
            n_left_q <= n_left_q - 16'd1;
            if (n_left_q == 16'd1) begin
              state_q <= ST_FIN;
            end else begin
              pc_q      <= pc_q + INS_ADDR_W'(1);
              rd_addr_q <= pc_q + INS_ADDR_W'(1);
              rd_en_q   <= 1'b1;
              state_q   <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_io.done_pulse       = done_q;
  assign ctrl_io.err_pulse        = err_q;
  assign ctrl_io.err_code         = err_code_q;
  assign ctrl_io.busy             = busy_q;
  assign ctrl_io.n_exec           = n_exec_q;
  assign ctrl_io.ins_ram_rd_en    = rd_en_q;
  assign ctrl_io.ins_ram_rd_addr  = rd_addr_q;
  assign ctrl_io.unit_ins         = unit_ins;
  assign ctrl_io.unit_start_pulse = start_q;

endmodule

// File: tb/tb_ins_dispatch_ctrl.sv
// Directed bench for ins_dispatch_ctrl with a 2-cycle instruction RAM model
// and execution units that answer a fixed number of cycles after their start.
module tb_ins_dispatch_ctrl;
  import ins_dispatch_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NU = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_dispatch_ctrl_if #(.INS_ADDR_W(AW), .INS_DW(DW), .N_UNITS(NU)) bus ();

  ins_dispatch_ctrl #(
    .INS_ADDR_W(AW), .INS_DW(DW), .OPC_W(8), .N_UNITS(NU), .RD_LAT(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instruction RAM: strobe in cycle c, data valid in cycle c+2, garbage otherwise.
  logic [DW-1:0] mem [0:1023];
  logic          v1;
  logic [AW-1:0] a1;
  always @(posedge clk) begin
    v1 <= bus.ins_ram_rd_en;
    a1 <= bus.ins_ram_rd_addr;
    bus.ins_ram_dout <= v1 ? mem[a1] : 32'hDEAD_BEE7;
  end

  // Execution units: done five cycles after the start pulse is seen.
  bit            auto_en = 1'b1;
  logic [NU-1:0] auto_done = '0;
  logic [NU-1:0] man_done = '0;
  logic [NU-1:0] resp_unit = '0;
  int            resp_cnt = 0;
  assign bus.unit_done_pulse = auto_done | man_done;
  always @(posedge clk) begin
    auto_done <= '0;
    if (rst) begin
      resp_cnt <= 0;
    end else if (auto_en && (|bus.unit_start_pulse)) begin
      resp_cnt  <= 4;
      resp_unit <= bus.unit_start_pulse;
    end else if (resp_cnt != 0) begin
      resp_cnt <= resp_cnt - 1;
      if (resp_cnt == 1) auto_done <= resp_unit;
    end
  end

  logic [AW-1:0] rd_log [$];
  logic [NU-1:0] st_log [$];
  logic [DW-1:0] ins_log [$];
  int done_cnt = 0, err_cnt = 0, first_st_cyc = 0, done_cyc = 0, start_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ins_ram_rd_en) rd_log.push_back(bus.ins_ram_rd_addr);
      if (|bus.unit_start_pulse) begin
        if (st_log.size() == 0) first_st_cyc = cyc;
        st_log.push_back(bus.unit_start_pulse);
        ins_log.push_back(bus.unit_ins);
      end
      if (bus.done_pulse) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.err_pulse) err_cnt++;
    end
  end

  task automatic launch(input logic [AW-1:0] base, input logic [15:0] cnt);
    rd_log.delete();
    st_log.delete();
    ins_log.delete();
    @(negedge clk);
    bus.ins_base_addr = base;
    bus.ins_count     = cnt;
    bus.start_pulse   = 1'b1;
    start_cyc         = cyc;
    @(negedge clk);
    bus.start_pulse   = 1'b0;
  endtask

  task automatic run_prog(input logic [AW-1:0] base, input logic [15:0] cnt, output bit timeout);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    launch(base, cnt);
    for (int i = 0; i < 200 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    timeout = (done_cnt == d0 && err_cnt == e0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.done_pulse !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_pulse); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_pulse); end
    checks++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", bus.err_code); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.n_exec !== 16'd0) begin errors++; $display("FAIL reset_n_exec got %0d want 0", bus.n_exec); end
    checks++; if (bus.ins_ram_rd_en !== 1'b0 || bus.ins_ram_rd_addr !== '0) begin errors++; $display("FAIL reset_rd got en=%b addr=%0d want 0/0", bus.ins_ram_rd_en, bus.ins_ram_rd_addr); end
    checks++; if (bus.unit_ins !== '0 || bus.unit_start_pulse !== '0) begin errors++; $display("FAIL reset_unit got ins=%h start=%b want 0/0", bus.unit_ins, bus.unit_start_pulse); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    bit to;
    logic [NU-1:0] exp_st [3];
    logic [DW-1:0] exp_ins [3];
    int d0;
    exp_st  = '{4'b0001, 4'b0010, 4'b0001};
    exp_ins = '{32'h1234_5601, 32'h00AB_CD02, 32'h7777_0001};
    d0 = done_cnt;
    run_prog(10'd0, 16'd3, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got none want done"); end
    checks++; if (st_log.size() != 3) begin errors++; $display("FAIL basic_nstarts got %0d want 3", st_log.size()); end
    for (int i = 0; i < 3 && i < st_log.size(); i++) begin
      checks++; if (st_log[i] !== exp_st[i] || ins_log[i] !== exp_ins[i]) begin errors++; $display("FAIL basic_start%0d got %b/%h want %b/%h", i, st_log[i], ins_log[i], exp_st[i], exp_ins[i]); end
    end
    checks++; if (rd_log.size() != 3 || rd_log[0] !== 10'd0 || rd_log[1] !== 10'd1 || rd_log[2] !== 10'd2) begin errors++; $display("FAIL basic_rd_addr got %p want 0,1,2", rd_log); end
    checks++; if (first_st_cyc - start_cyc != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", first_st_cyc - start_cyc); end
    checks++; if (bus.n_exec !== 16'd3) begin errors++; $display("FAIL basic_n_exec got %0d want 3", bus.n_exec); end
    checks++; if (done_cnt - d0 != 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_done got pulses=%0d busy=%b want 1/0", done_cnt - d0, bus.busy); end
    $display("basic: starts=%0d n_exec=%0d", st_log.size(), bus.n_exec);
  endtask

  task automatic test_zero_count();
    bit to;
    run_prog(10'd5, 16'd0, to);
    checks++; if (to || done_cyc - start_cyc != 2) begin errors++; $display("FAIL zero_done_lat got %0d want 2", done_cyc - start_cyc); end
    checks++; if (rd_log.size() != 0 || bus.n_exec !== 16'd0) begin errors++; $display("FAIL zero_idle got rd=%0d n_exec=%0d want 0/0", rd_log.size(), bus.n_exec); end
    $display("zero_count: done after %0d cycles", done_cyc - start_cyc);
  endtask

  task automatic test_end_opcode();
    bit to;
    int d0;
    d0 = done_cnt;
    run_prog(10'd10, 16'd3, to);
    checks++; if (to || done_cnt - d0 != 1) begin errors++; $display("FAIL end_done got %0d want 1", done_cnt - d0); end
    checks++; if (st_log.size() != 1 || st_log[0] !== 4'b0001) begin errors++; $display("FAIL end_starts got %p want 0001", st_log); end
    checks++; if (bus.n_exec !== 16'd1 || rd_log.size() != 2) begin errors++; $display("FAIL end_n_exec got %0d rd=%0d want 1/2", bus.n_exec, rd_log.size()); end
    $display("end_opcode: n_exec=%0d", bus.n_exec);
  endtask

  task automatic test_illegal();
    bit to;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    run_prog(10'd20, 16'd1, to);
    checks++; if (to || err_cnt - e0 != 1 || done_cnt != d0) begin errors++; $display("FAIL illegal_pulse got err=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0); end
    checks++; if (bus.err_code !== 2'd1) begin errors++; $display("FAIL illegal_code got %0d want 1", bus.err_code); end
    checks++; if (st_log.size() != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_nostart got %0d busy=%b want 0/0", st_log.size(), bus.busy); end
    $display("illegal: err_code=%0d", bus.err_code);
  endtask

  task automatic test_spurious();
    bit to;
    int e0;
    e0 = err_cnt;
    auto_en = 1'b0;
    launch(10'd30, 16'd2);
    for (int i = 0; i < 50 && st_log.size() == 0; i++) @(negedge clk);
    checks++; if (st_log.size() != 1 || st_log[0] !== 4'b0001) begin errors++; $display("FAIL spur_first_start got %p want 0001", st_log); end
    @(negedge clk);
    man_done = 4'b0100;
    @(negedge clk);
    man_done = '0;
    for (int i = 0; i < 20 && err_cnt == e0; i++) @(negedge clk);
    @(negedge clk);
    checks++; if (err_cnt - e0 != 1 || bus.err_code !== 2'd2) begin errors++; $display("FAIL spur_err got pulses=%0d code=%0d want 1/2", err_cnt - e0, bus.err_code); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_busy got %b want 0", bus.busy); end
    auto_en = 1'b1;
    run_prog(10'd0, 16'd1, to);
    checks++; if (to || bus.err_code !== 2'd0 || bus.n_exec !== 16'd1) begin errors++; $display("FAIL spur_restart got code=%0d n_exec=%0d want 0/1", bus.err_code, bus.n_exec); end
    $display("spurious: error code cleared by restart");
  endtask

  task automatic test_wrap();
    bit to;
    run_prog(10'd1023, 16'd2, to);
    checks++; if (to || rd_log.size() != 2 || rd_log[0] !== 10'd1023 || rd_log[1] !== 10'd0) begin errors++; $display("FAIL wrap_rd got %p want 1023,0", rd_log); end
    checks++; if (st_log.size() != 2 || st_log[0] !== 4'b0010 || st_log[1] !== 4'b0001) begin errors++; $display("FAIL wrap_starts got %p want 0010,0001", st_log); end
    $display("wrap: rd_addr sequence checked");
  endtask

  task automatic test_reset_mid();
    bit to;
    int d0;
    launch(10'd0, 16'd3);
    for (int i = 0; i < 50 && st_log.size() == 0; i++) @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.n_exec !== 16'd0 || bus.unit_ins !== '0 || bus.unit_start_pulse !== '0 || bus.err_code !== 2'd0) begin errors++; $display("FAIL midrst_outputs got busy=%b n_exec=%0d ins=%h want 0", bus.busy, bus.n_exec, bus.unit_ins); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrst_nodone got %0d want 0", done_cnt - d0); end
    run_prog(10'd0, 16'd3, to);
    checks++; if (to || bus.n_exec !== 16'd3 || st_log.size() != 3) begin errors++; $display("FAIL midrst_rerun got n_exec=%0d starts=%0d want 3/3", bus.n_exec, st_log.size()); end
    $display("reset_mid: rerun n_exec=%0d", bus.n_exec);
  endtask

  initial begin
    bus.start_pulse   = 1'b0;
    bus.ins_base_addr = '0;
    bus.ins_count     = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h1234_5601;
    mem[1]    = 32'h00AB_CD02;
    mem[2]    = 32'h7777_0001;
    mem[10]   = 32'h0000_0001;
    mem[11]   = 32'h0000_0000;
    mem[12]   = 32'h0000_0003;
    mem[20]   = 32'h0000_0007;
    mem[30]   = 32'h0000_0001;
    mem[31]   = 32'h0000_0001;
    mem[1023] = 32'h0000_0002;
    test_reset();
    test_basic();
    test_zero_count();
    test_end_opcode();
    test_illegal();
    test_spurious();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
